// File: rtl/period_meter.sv
// period_meter: after an i_start pulse, measures i_sig period/high time in sysclk cycles; result 1 cycle after the closing rise (+2 with PERIOD_METER_SYNC_EN).
// No backpressure: o_valid/o_timeout are single-cycle strobes, and i_start is ignored while busy.
module period_meter #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 24_000_000
) (
  input  logic             sysclk,
  input  logic             i_rst_n,
  input  logic             i_sig,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_MEAS} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  logic             sig_s;
  logic             sig_d_q;
  logic             rise;
  logic             fall;
  logic             tc;
  logic             busy_q;
  logic             valid_q;
  logic             timeout_q;
  logic             high_done_q;
  logic [CNT_W-1:0] tcnt_q;
  logic [CNT_W-1:0] per_cnt_q;
  logic [CNT_W-1:0] high_cnt_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;

`ifdef PERIOD_METER_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_sig;
      sync2_q <= sync1_q;
    end
  end

  assign sig_s = sync2_q;
`else
  assign sig_s = i_sig;
`endif

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sig_d_q <= 1'b0;
    end else begin
      sig_d_q <= sig_s;
    end
  end

  assign rise = sig_s & ~sig_d_q;
  assign fall = ~sig_s & sig_d_q;
  assign tc   = (tcnt_q == TO_LAST);

  always_ff @(posedge sysclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
      high_done_q <= 1'b0;
      tcnt_q      <= '0;
      per_cnt_q   <= '0;
      high_cnt_q  <= '0;
      period_q    <= '0;
      high_q      <= '0;
    end else begin
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
            tcnt_q  <= '0;
          end
        end
        S_ARM: begin
          tcnt_q <= tcnt_q + ONE;
          // A rise sampled together with i_start never reaches here, so it is not used.
          if (rise) begin
            state_q     <= S_MEAS;
            per_cnt_q   <= ONE;
            high_cnt_q  <= ONE;
            high_done_q <= 1'b0;
          end else if (tc) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        S_MEAS: begin
          tcnt_q    <= tcnt_q + ONE;
          per_cnt_q <= per_cnt_q + ONE;
          // The fall-detect cycle itself is not counted as high time.
          if (!high_done_q && !fall) begin
            high_cnt_q <= high_cnt_q + ONE;
          end
          if (fall) begin
            high_done_q <= 1'b1;
          end
          if (rise) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b1;
            period_q <= per_cnt_q;
            high_q   <= high_cnt_q;
          end else if (tc) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_valid   = valid_q;
  assign o_timeout = timeout_q;
  assign o_period  = period_q;
  assign o_high    = high_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: timestamp-based reference model checked every cycle, plus directed literal checks.
module tb_period_meter;

  localparam int CNT_W = 32;
  localparam int TO    = 100;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic             sysclk  = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic             man_sig = 1'b0;
  logic             gen_en  = 1'b0;
  logic             gen_sig = 1'b0;
  logic             i_sig;
  logic             o_busy;
  logic             o_valid;
  logic             o_timeout;
  logic [CNT_W-1:0] o_period;
  logic [CNT_W-1:0] o_high;

  int gen_hi  = 5;
  int gen_lo  = 5;
  int gen_cnt = 0;
  int errors  = 0;
  int checks  = 0;

  assign i_sig = gen_en ? gen_sig : man_sig;

  period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .sysclk    (sysclk),
    .i_rst_n   (i_rst_n),
    .i_sig     (i_sig),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_valid   (o_valid),
    .o_timeout (o_timeout),
    .o_period  (o_period),
    .o_high    (o_high)
  );

  always #5 sysclk = ~sysclk;

  // Periodic stimulus: gen_hi cycles high, then gen_lo cycles low.
  always @(negedge sysclk) begin
    if (!gen_en) begin
      gen_cnt <= 0;
      gen_sig <= 1'b0;
    end else begin
      gen_sig <= (gen_cnt < gen_hi);
      gen_cnt <= (gen_cnt + 1 >= gen_hi + gen_lo) ? 0 : gen_cnt + 1;
    end
  end

  // Reference model: timestamps of start, first rise and fall, evaluated per clock edge.
  longint           ecnt    = 0;
  longint           t_start = 0;
  longint           t_r1    = 0;
  longint           t_f     = -1;
  int               m_mode  = 0;
  logic [2:0]       hist    = 3'b000;
  logic             s_prev  = 1'b0;
  logic             exp_busy = 1'b0;
  logic             exp_valid = 1'b0;
  logic             exp_to  = 1'b0;
  logic [CNT_W-1:0] exp_per = '0;
  logic [CNT_W-1:0] exp_high = '0;

  initial begin
    logic s_now, rise, fall;
    forever begin
      @(posedge sysclk or negedge i_rst_n);
      if (!i_rst_n) begin
        m_mode = 0; hist = 3'b000; s_prev = 1'b0;
        exp_busy = 1'b0; exp_valid = 1'b0; exp_to = 1'b0;
        exp_per = '0; exp_high = '0;
      end else begin
        ecnt++;
        hist   = {hist[1:0], i_sig};
        s_now  = hist[LAT];
        rise   = s_now & ~s_prev;
        fall   = ~s_now & s_prev;
        s_prev = s_now;
        exp_valid = 1'b0;
        exp_to    = 1'b0;
        case (m_mode)
          0: if (i_start) begin
            m_mode = 1; t_start = ecnt; exp_busy = 1'b1;
          end
          1: if (rise) begin
            m_mode = 2; t_r1 = ecnt; t_f = -1;
          end else if (ecnt - t_start == TO) begin
            m_mode = 0; exp_to = 1'b1; exp_busy = 1'b0;
          end
          default: if (rise) begin
            exp_per   = CNT_W'(ecnt - t_r1);
            exp_high  = CNT_W'(t_f - t_r1);
            exp_valid = 1'b1; exp_busy = 1'b0; m_mode = 0;
          end else begin
            if (fall && t_f < 0) t_f = ecnt;
            if (ecnt - t_start == TO) begin
              m_mode = 0; exp_to = 1'b1; exp_busy = 1'b0;
            end
          end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge sysclk);
      checks++;
      if (o_busy !== exp_busy || o_valid !== exp_valid || o_timeout !== exp_to ||
          o_period !== exp_per || o_high !== exp_high) begin
        errors++;
        $display("FAIL model_cycle t=%0t busy=%b/%b valid=%b/%b timeout=%b/%b period=%0d/%0d high=%0d/%0d (actual/expected)",
                 $time, o_busy, exp_busy, o_valid, exp_valid, o_timeout, exp_to,
                 o_period, exp_per, o_high, exp_high);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge sysclk);
    i_start = 1'b0;
  endtask

  task automatic wait_result(input string name, input int bound, output bit gv, output bit gt,
                             output longint per, output longint hi);
    bit found;
    found = 1'b0; gv = 1'b0; gt = 1'b0; per = 0; hi = 0;
    for (int k = 0; k < bound && !found; k++) begin
      @(negedge sysclk);
      if (o_valid || o_timeout) begin
        found = 1'b1; gv = o_valid; gt = o_timeout;
        per = longint'(o_period); hi = longint'(o_high);
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_wait actual=no_result expected=result_within_%0d_cycles", name, bound);
    end
  endtask

  task automatic set_gen(input int hi, input int lo);
    gen_en = 1'b0;
    man_sig = 1'b0;
    repeat (4) @(negedge sysclk);
    gen_hi = hi;
    gen_lo = lo;
    gen_en = 1'b1;
    repeat (3) @(negedge sysclk);
  endtask

  task automatic gen_off();
    gen_en = 1'b0;
    man_sig = 1'b0;
    repeat (5) @(negedge sysclk);
  endtask

  initial begin
    bit     gv, gt, seen, prev;
    longint per, hi;
    int     vcyc, tcyc, nval;

    repeat (3) @(negedge sysclk);
    chk("reset_busy", longint'(o_busy), 0);
    chk("reset_valid", longint'(o_valid), 0);
    chk("reset_timeout", longint'(o_timeout), 0);
    chk("reset_period", longint'(o_period), 0);
    chk("reset_high", longint'(o_high), 0);
    i_rst_n = 1'b1;
    @(negedge sysclk);

    // Symmetric toggle every 5 cycles.
    set_gen(5, 5);
    pulse_start();
    wait_result("sym5", 60, gv, gt, per, hi);
    chk("sym5_valid", longint'(gv), 1);
    chk("sym5_period", per, 10);
    chk("sym5_high", hi, 5);
    @(negedge sysclk);
    chk("sym5_busy_after", longint'(o_busy), 0);

    // Minimum period.
    set_gen(1, 1);
    pulse_start();
    wait_result("min2", 20, gv, gt, per, hi);
    chk("min2_period", per, 2);
    chk("min2_high", hi, 1);

    // Asymmetric high 3 / low 7 with exact latency.
    gen_off();
    vcyc = -1;
    per = 0; hi = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 0) chk("asym_busy_pre", longint'(o_busy), 0);
      if (c == 1) chk("asym_busy_rise", longint'(o_busy), 1);
      if (o_valid && vcyc < 0) begin
        vcyc = c; per = longint'(o_period); hi = longint'(o_high);
      end
      i_start = (c == 0);
      man_sig = (c >= 2 && c < 5) || (c >= 12 && c < 15);
      @(negedge sysclk);
    end
    chk("asym_valid_cycle", vcyc, 13 + LAT);
    chk("asym_period", per, 10);
    chk("asym_high", hi, 3);

    // Timeout with signal held low.
    gen_off();
    tcyc = -1;
    for (int c = 0; c < 110; c++) begin
      if (o_timeout && tcyc < 0) tcyc = c;
      i_start = (c == 0);
      @(negedge sysclk);
    end
    chk("to_cycle", tcyc, 101);
    chk("to_period_kept", longint'(o_period), 10);
    chk("to_high_kept", longint'(o_high), 3);

    // Closing rise on the terminal-count edge: rise wins.
    gen_off();
    vcyc = -1; tcyc = -1;
    for (int c = 0; c < 110; c++) begin
      if (o_valid && vcyc < 0) begin
        vcyc = c; per = longint'(o_period); hi = longint'(o_high);
      end
      if (o_timeout && tcyc < 0) tcyc = c;
      i_start = (c == 0);
      man_sig = (c >= 50 - LAT && c < 70 - LAT) || (c >= 100 - LAT);
      @(negedge sysclk);
    end
    chk("tc_rise_valid_cycle", vcyc, 101);
    chk("tc_rise_no_timeout", tcyc, -1);
    chk("tc_rise_period", per, 50);
    chk("tc_rise_high", hi, 20);

    // Closing rise one edge too late: timeout, results kept.
    gen_off();
    vcyc = -1; tcyc = -1;
    for (int c = 0; c < 110; c++) begin
      if (o_valid && vcyc < 0) vcyc = c;
      if (o_timeout && tcyc < 0) tcyc = c;
      i_start = (c == 0);
      man_sig = (c >= 50 - LAT && c < 70 - LAT) || (c >= 101 - LAT);
      @(negedge sysclk);
    end
    chk("late_rise_timeout_cycle", tcyc, 101);
    chk("late_rise_no_valid", vcyc, -1);
    chk("late_rise_period_kept", longint'(o_period), 50);

    // Extra start pulses while busy are ignored.
    set_gen(8, 12);
    pulse_start();
    nval = 0; per = 0; hi = 0;
    for (int k = 0; k < 80; k++) begin
      if (o_valid) begin
        nval++; per = longint'(o_period); hi = longint'(o_high);
      end
      if (!o_busy) break;
      i_start = (k % 3 == 1);
      @(negedge sysclk);
    end
    i_start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge sysclk);
      if (o_valid) nval++;
    end
    chk("restart_valid_count", nval, 1);
    chk("restart_period", per, 20);
    chk("restart_high", hi, 8);

    // Asynchronous reset in MEASURE.
    gen_off();
    for (int c = 0; c < 6; c++) begin
      i_start = (c == 0);
      man_sig = (c >= 2);
      @(negedge sysclk);
    end
    chk("mid_rst_busy_pre", longint'(o_busy), 1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", longint'(o_busy), 0);
    chk("mid_rst_period", longint'(o_period), 0);
    chk("mid_rst_high", longint'(o_high), 0);
    chk("mid_rst_valid", longint'(o_valid), 0);
    chk("mid_rst_timeout", longint'(o_timeout), 0);
    man_sig = 1'b0;
    repeat (2) @(negedge sysclk);
    i_rst_n = 1'b1;
    set_gen(10, 10);
    pulse_start();
    wait_result("post_rst", 80, gv, gt, per, hi);
    chk("post_rst_valid", longint'(gv), 1);
    chk("post_rst_period", per, 20);
    chk("post_rst_high", hi, 10);

    // Long period aligned so it completes inside the timeout window.
    set_gen(45, 45);
    seen = 1'b0; prev = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge sysclk);
      if (prev && !i_sig) seen = 1'b1;
      prev = i_sig;
    end
    chk("long_fall_seen", longint'(seen), 1);
    repeat (40) @(negedge sysclk);
    pulse_start();
    wait_result("long90", 120, gv, gt, per, hi);
    chk("long90_valid", longint'(gv), 1);
    chk("long90_period", per, 90);
    chk("long90_high", hi, 45);

    gen_off();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
